// File: rtl/linebuffer_window9x9.sv
// linebuffer_window9x9: streams every valid 9x9 window of a raster image; LB_WIN_POS_EN adds win_row/win_col
module linebuffer_window9x9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 9,
  parameter int PIX_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_sof,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [K*K*PIX_W-1:0]   win_data,
  output logic                   win_valid,
  input  logic                   win_ready
`ifdef LB_WIN_POS_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LW = (K-1)*PIX_W;
  logic [CW-1:0]        col, ec, col_nx;
  logic [RW-1:0]        row, er, row_nx;
  logic [LW-1:0]        lb [IMG_W];
  logic [LW-1:0]        rd;
  logic [K*PIX_W-1:0]   newc;
  logic [K*K*PIX_W-1:0] win_nx;
  logic                 acc, emit, eol;
  assign pix_ready = !win_valid || win_ready;
  assign acc       = pix_valid && pix_ready;
  // sof relocates the incoming pixel to (0,0) before anything else looks at the counters
  assign ec        = pix_sof ? '0 : col;
  assign er        = pix_sof ? '0 : row;
  assign eol       = ec == CW'(IMG_W-1);
  assign col_nx    = eol ? '0 : ec + 1'b1;
  assign row_nx    = !eol ? er : er == RW'(IMG_H-1) ? '0 : er + 1'b1;
  assign emit      = er >= RW'(K-1) && ec >= CW'(K-1);
  // buffered rows sit oldest-first in the low bits, so the new column is just {pixel, rows}
  assign rd        = lb[ec];
  assign newc      = {pix_in, rd};
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      if (c == K-1) begin : g_new
        assign win_nx[(r*K+c)*PIX_W +: PIX_W] = newc[r*PIX_W +: PIX_W];
      end else begin : g_shift
        assign win_nx[(r*K+c)*PIX_W +: PIX_W] = win_data[(r*K+c+1)*PIX_W +: PIX_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc) lb[ec] <= newc[K*PIX_W-1:PIX_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
    end else begin
      win_valid <= acc ? emit : win_valid && !win_ready;
      if (acc) begin
        col      <= col_nx;
        row      <= row_nx;
        win_data <= win_nx;
      end
    end
  end
`ifdef LB_WIN_POS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row <= '0;
      win_col <= '0;
    end else if (acc && emit) begin
      win_row <= er - RW'(K-1);
      win_col <= ec - CW'(K-1);
    end
  end
`endif
endmodule

// File: tb/tb_linebuffer_window9x9.sv
// tb_linebuffer_window9x9: directed checks of window contents, counts, backpressure, sof and reset
module tb_linebuffer_window9x9;
  localparam int IW = 28, IH = 28, PW = 7, WB = 81*PW;
  typedef struct {int r; int c;} pos_t;
  logic clk = 0, rst_n = 0;
  logic [PW-1:0] pix_in = '0;
  logic pix_sof = 0, pix_valid = 0, win_ready = 1;
  logic pix_ready, win_valid;
  logic [WB-1:0] win_data;
  int checks = 0, errors = 0;
  int wins, data_bad, runs, bad_runs, stall_bad, hold_bad, stall_seen, first_acc, pos_bad;
  logic [WB-1:0] first_win, last_win;
  pos_t first_pos, last_pos;
`ifdef LB_WIN_POS_EN
  logic [4:0] win_row, win_col;
`endif
  linebuffer_window9x9 #(.IMG_W(IW), .IMG_H(IH), .K(9), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready)
`ifdef LB_WIN_POS_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [PW-1:0] pv(int r, int c, int off);
    return PW'((r*IW + c + off) % 128);
  endfunction
  task automatic stream(input int n, input bit sof, input int off, input int stall, input bit drain);
    int k = 0, cyc = 0, r, c, run = 0, left = stall;
    pos_t q[$];
    pos_t e;
    logic [WB-1:0] prev, exp_w;
    wins = 0; data_bad = 0; runs = 0; bad_runs = 0; stall_bad = 0; hold_bad = 0;
    stall_seen = 0; first_acc = -1; pos_bad = 0; prev = '0;
    while ((k < n || (drain && (win_valid || q.size() != 0))) && cyc < 4*n + 200) begin
      @(negedge clk);
      cyc++;
      r = (k / IW) % IH;
      c = k % IW;
      pix_valid = k < n;
      pix_in = pv(r, c, off);
      pix_sof = sof && k == 0;
      if (win_valid && left > 0) begin
        win_ready = 0;
        left--;
      end else win_ready = 1;
      #1;
      if (!win_ready) begin
        stall_seen++;
        if (pix_ready !== 1'b0) stall_bad++;
        if (stall_seen > 1 && win_data !== prev) hold_bad++;
      end
      prev = win_data;
      if (win_valid) run++;
      else if (run > 0) begin
        runs++;
        if (run != 20) bad_runs++;
        run = 0;
      end
      if (win_valid && win_ready) begin
        wins++;
        if (wins == 1) first_acc = k;
        if (q.size() == 0) data_bad++;
        else begin
          e = q.pop_front();
          for (int i = 0; i < 81; i++) exp_w[i*PW +: PW] = pv(e.r + i/9, e.c + i%9, off);
          if (win_data !== exp_w) data_bad++;
`ifdef LB_WIN_POS_EN
          if (win_row !== 5'(e.r) || win_col !== 5'(e.c)) pos_bad++;
`endif
          if (wins == 1) begin first_win = win_data; first_pos = e; end
          last_win = win_data;
          last_pos = e;
        end
      end
      if (pix_valid && pix_ready) begin
        if (r >= 8 && c >= 8) q.push_back('{r - 8, c - 8});
        k++;
      end
    end
    if (run > 0) begin
      runs++;
      if (run != 20) bad_runs++;
    end
    if (cyc >= 4*n + 200) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d of %0d pixels", k, n);
    end
    @(posedge clk);
    #1;
    pix_valid = 0;
    pix_sof = 0;
    win_ready = 1;
  endtask
  task automatic test_reset;
    #3;
    checks += 2;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", win_valid); end
    if (win_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", win_data); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
  endtask
  task automatic test_full_frame;
    stream(IW*IH, 0, 0, 0, 1);
    checks += 7;
    if (wins !== 400) begin errors++; $display("FAIL full_count: got %0d want 400", wins); end
    if (data_bad !== 0) begin errors++; $display("FAIL full_data: %0d bad windows want 0", data_bad); end
    if (first_win[0 +: PW] !== 7'd0) begin errors++; $display("FAIL full_e0: got %0d want 0", first_win[0 +: PW]); end
    if (first_win[8*PW +: PW] !== 7'd8) begin errors++; $display("FAIL full_e8: got %0d want 8", first_win[8*PW +: PW]); end
    if (first_win[72*PW +: PW] !== 7'd96) begin errors++; $display("FAIL full_e72: got %0d want 96", first_win[72*PW +: PW]); end
    if (first_win[80*PW +: PW] !== 7'd104) begin errors++; $display("FAIL full_e80: got %0d want 104", first_win[80*PW +: PW]); end
    if (last_win[80*PW +: PW] !== 7'd15) begin errors++; $display("FAIL full_last_e80: got %0d want 15", last_win[80*PW +: PW]); end
  endtask
  task automatic test_back_to_back;
    stream(IW*IH, 0, 0, 0, 1);
    checks += 3;
    if (runs !== 20) begin errors++; $display("FAIL b2b_runs: got %0d want 20", runs); end
    if (bad_runs !== 0) begin errors++; $display("FAIL b2b_run_len: %0d runs not 20 long want 0", bad_runs); end
    if (data_bad !== 0) begin errors++; $display("FAIL b2b_data: %0d bad windows want 0", data_bad); end
  endtask
  task automatic test_backpressure;
    stream(IW*IH, 0, 0, 5, 1);
    checks += 5;
    if (wins !== 400) begin errors++; $display("FAIL bp_count: got %0d want 400", wins); end
    if (stall_seen !== 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_seen); end
    if (stall_bad !== 0) begin errors++; $display("FAIL bp_ready: pix_ready high in %0d stall cycles want 0", stall_bad); end
    if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold: data moved in %0d stall cycles want 0", hold_bad); end
    if (data_bad !== 0) begin errors++; $display("FAIL bp_data: %0d bad windows want 0", data_bad); end
  endtask
  task automatic test_sof_mid_frame;
    stream(12*IW + 5, 1, 0, 0, 1);
    checks++;
    if (wins !== 80) begin errors++; $display("FAIL sof_partial_count: got %0d want 80", wins); end
    stream(IW*IH, 1, 50, 0, 1);
    checks += 4;
    if (first_acc !== 233) begin errors++; $display("FAIL sof_first_latency: first window after %0d pixels want 233", first_acc); end
    if (first_win[0 +: PW] !== 7'd50) begin errors++; $display("FAIL sof_e0: got %0d want 50", first_win[0 +: PW]); end
    if (wins !== 400) begin errors++; $display("FAIL sof_count: got %0d want 400", wins); end
    if (data_bad !== 0) begin errors++; $display("FAIL sof_data: %0d bad windows want 0", data_bad); end
  endtask
  task automatic test_reset_mid_frame;
    stream(8*IW + 10, 0, 0, 0, 0);
    #1;
    checks++;
    if (win_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b want 1", win_valid); end
    rst_n = 0;
    #1;
    checks += 2;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", win_valid); end
    if (win_data !== '0) begin errors++; $display("FAIL rstmid_data: got %h want 0", win_data); end
    @(negedge clk);
    rst_n = 1;
    stream(IW*IH, 0, 0, 0, 1);
    checks += 3;
    if (wins !== 400) begin errors++; $display("FAIL rstmid_count: got %0d want 400", wins); end
    if (first_win[80*PW +: PW] !== 7'd104) begin errors++; $display("FAIL rstmid_e80: got %0d want 104", first_win[80*PW +: PW]); end
    if (data_bad !== 0) begin errors++; $display("FAIL rstmid_data_frame: %0d bad windows want 0", data_bad); end
  endtask
`ifdef LB_WIN_POS_EN
  task automatic test_win_pos;
    stream(IW*IH, 0, 0, 0, 1);
    checks += 5;
    if (pos_bad !== 0) begin errors++; $display("FAIL pos_track: %0d windows with wrong position want 0", pos_bad); end
    if (first_pos.r !== 0 || first_pos.c !== 0) begin errors++; $display("FAIL pos_first_model: got (%0d,%0d) want (0,0)", first_pos.r, first_pos.c); end
    if (last_pos.r !== 19 || last_pos.c !== 19) begin errors++; $display("FAIL pos_last_model: got (%0d,%0d) want (19,19)", last_pos.r, last_pos.c); end
    if (win_row !== 5'd19) begin errors++; $display("FAIL pos_last_row: got %0d want 19", win_row); end
    if (win_col !== 5'd19) begin errors++; $display("FAIL pos_last_col: got %0d want 19", win_col); end
  endtask
`endif
  initial begin
    test_reset;
    test_full_frame;
    test_back_to_back;
    test_backpressure;
    test_sof_mid_frame;
    test_reset_mid_frame;
`ifdef LB_WIN_POS_EN
    test_win_pos;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
